bram_port_arbiter: RTL and testbench
====================================

Name: bram_port_arbiter

Overview:
- Round-robin arbiter that shares the single fabric-side port of the 512x32 JTAG-visible block RAM between NREQ on-chip requesters.
- Sits on the fabric clock domain, between the user logic and RAM port B. The JTAG side (port A) is untouched.
- Gives each requester a req/gnt handshake and a read-return valid. Issues at most one RAM access per cycle.

Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 9, RAM word-address width
- DW, 32, RAM data width

Ports:
- clk_p  in  1  fabric clock; RAM port clock
- rst_top  in  1  asynchronous active-low reset
- req_i  in  NREQ  per-requester access request
- we_i  in  NREQ  per-requester write (1) / read (0)
- addr_i  in  NREQ*AW  packed addresses; requester i uses slice [i*AW +: AW]
- wdata_i  in  NREQ*DW  packed write data; requester i uses slice [i*DW +: DW]
- lock_i  in  NREQ  bus-lock request; present only with ARB_LOCK_EN
- gnt_o  out  NREQ  one-hot grant pulse
- rvalid_o  out  NREQ  one-hot read-data-valid pulse
- rdata_o  out  DW  read data, shared by all requesters
- ram_en_o  out  1  RAM enable
- ram_we_o  out  1  RAM write enable
- ram_addr_o  out  AW  RAM address
- ram_wdata_o  out  DW  RAM write data
- ram_rdata_i  in  DW  RAM read data (synchronous, 1-cycle read latency)

Behaviour:
- Reset (rst_top low, asynchronous): gnt_o=0, rvalid_o=0, ram_en_o=0, ram_we_o=0, ram_addr_o=0, ram_wdata_o=0, priority pointer ptr=0, lock owner cleared.
- Each cycle, the arbiter evaluates eligible = req_i & ~gnt_o.
  - A requester granted in the current cycle is masked for that cycle's decision, so no double issue occurs.
  - Consequence: one requester gets at most one access every 2 cycles.
- Selection: first eligible index searching ptr, ptr+1, ... NREQ-1, 0, ... ptr-1 (modulo NREQ).
- On selection of k (registered, visible the next cycle):
  - gnt_o = 1<<k
  - ram_en_o = 1, ram_we_o = we_i[k], ram_addr_o = addr_k, ram_wdata_o = wdata_k
  - ptr = (k+1) mod NREQ
- No eligible request: gnt_o=0, ram_en_o=0, ram_we_o=0; ram_addr_o and ram_wdata_o hold; ptr holds.
- Latency: request sampled in cycle N -> gnt_o and RAM access in cycle N+1 -> RAM captures at end of N+1 -> for reads, rvalid_o[k]=1 in cycle N+2.
- Read return path:
  - rdata_o = ram_rdata_i, combinational pass-through.
  - rvalid_o = registered (gnt_o & {NREQ{ram_en_o & ~ram_we_o}}).
  - Writes never produce rvalid_o.
- Requester rules:
  - Hold we/addr/wdata stable from raising req until the cycle gnt_o[i] is high.
  - Deassert or change req/we/addr/wdata in the cycle after gnt.
  - A req dropped before grant is legal: no access occurs and no state is retained for it.
- Simultaneous events:
  - All requesters asserting continuously are served strictly in rotation.
  - A single continuous requester is granted every other cycle.
- Reset mid-transaction: any pending rvalid is discarded; a granted write already clocked into the RAM is not undone.
- Out-of-range NREQ is a compile-time error (generate-time assertion).

Optional Feature:
- Macro ARB_LOCK_EN.
- Defined:
  - lock_i port exists.
  - When requester k is granted with lock_i[k]=1, k becomes lock owner. Only k is eligible until a cycle in which lock_i[k]=0.
  - The owner is still subject to the gnt mask, so it gets at most 1 access per 2 cycles. ptr is frozen at k+1 while locked.
  - Reset or lock_i[k] deassertion clears ownership immediately, effective on the same-cycle decision.
- Undefined: no lock_i port, no lock state; pure round-robin.

Decomposition:
- Package bram_arb_pkg: RAM_AW=9, RAM_DW=32, NREQ_MAX=8, and a typedef for one request bundle {we, addr, wdata}.
- One sub-module, rr_pick: purely combinational round-robin picker. Inputs: eligible vector and ptr. Outputs: one-hot pick and found flag. Reused elsewhere by the team.

Test Plan:
- Reset, idle: rst_top low then high, all req_i=0 -> every output 0 for 20 cycles.
- Single read, round trip: RAM preloaded word 0x005=0xDEADBEEF. Req 2 read addr 0x005 at cycle N -> gnt_o=4'b0100 and ram_addr_o=0x005 at N+1, rvalid_o=4'b0100 with rdata_o=0xDEADBEEF at N+2.
- Write then read: req 1 writes 0x1A5 <- 0x12345678, then req 3 reads 0x1A5 -> rdata 0x12345678, and rvalid_o never high for req 1.
- Fairness: all four req_i held high for 16 cycles from reset -> grant order 0,1,2,3,0,1,..., 4 grants each, no cycle with two gnt bits set.
- Single continuous requester: req 0 held 10 cycles -> gnt_o[0] toggles 1,0,1,0, 5 grants.
- Mid-operation reset: rst_top pulsed low in the cycle between read grant and rvalid -> rvalid_o stays 0 and ptr returns to 0. With ARB_LOCK_EN: req 1 locked, req 0/2 active for 8 cycles -> only req 1 granted; after lock drops, the next grant goes to req 2.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// -----------------------------------------------------------------------------
// bram_arb_pkg
//   Shared constants and types for the fabric-side block RAM port arbiter.
//   RAM_AW / RAM_DW describe the 512x32 JTAG-visible RAM; NREQ_MAX bounds the
//   number of requesters the arbiter can be built with.
// -----------------------------------------------------------------------------
package bram_arb_pkg;

    localparam int RAM_AW   = 9;
    localparam int RAM_DW   = 32;
    localparam int NREQ_MAX = 8;

    // One requester's access description, as presented alongside req.
    typedef struct packed {
        logic              we;
        logic [RAM_AW-1:0] addr;
        logic [RAM_DW-1:0] wdata;
    } req_bundle_t;

    // Successor of k in a ring of n slots.
    function automatic int unsigned wrap_inc(input int unsigned k, input int unsigned n);
        return (k + 1 >= n) ? 0 : k + 1;
    endfunction

endpackage

// File: rtl/bram_port_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Purely combinational round-robin picker. Searches eligible starting at
//   index ptr and wrapping modulo N; returns the first hit as a one-hot pick.
//
//   Ports:
//     eligible  in   N          candidates for this decision
//     ptr       in   $clog2(N)  index searched first
//     pick      out  N          one-hot winner (all zero if none)
//     found     out  1          a winner exists
// -----------------------------------------------------------------------------
module rr_pick
    import bram_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         eligible,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         pick,
    output logic                 found
);

    int idx;

    // NOTE: every signal driven here gets a default before the search loop;
    // leaving any path unassigned would infer a latch.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && eligible[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// bram_port_arbiter
//   Round-robin arbiter sharing RAM port B (fabric clock domain) between NREQ
//   requesters. One RAM access per cycle, registered grant, 1-cycle RAM read
//   latency returned as a one-hot rvalid pulse two cycles after the request
//   is sampled.
//
//   Optional build macro ARB_LOCK_EN adds lock_i: a requester granted with its
//   lock bit set becomes the sole eligible requester until its lock drops.
//
//   Ports:
//     clk_p        in   1        fabric clock / RAM port clock
//     rst_top      in   1        asynchronous active-low reset
//     req_i        in   NREQ     access requests
//     we_i         in   NREQ     write (1) / read (0) per requester
//     addr_i       in   NREQ*AW  packed addresses, requester i at [i*AW +: AW]
//     wdata_i      in   NREQ*DW  packed write data, requester i at [i*DW +: DW]
//     lock_i       in   NREQ     bus lock request (ARB_LOCK_EN only)
//     gnt_o        out  NREQ     one-hot grant pulse
//     rvalid_o     out  NREQ     one-hot read-data-valid pulse
//     rdata_o      out  DW       read data (shared)
//     ram_en_o     out  1        RAM enable
//     ram_we_o     out  1        RAM write enable
//     ram_addr_o   out  AW       RAM address
//     ram_wdata_o  out  DW       RAM write data
//     ram_rdata_i  in   DW       RAM read data, valid 1 cycle after access
// -----------------------------------------------------------------------------
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = RAM_AW,
    parameter int DW   = RAM_DW
) (
    input  logic               clk_p,
    input  logic               rst_top,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ-1:0]    we_i,
    input  logic [NREQ*AW-1:0] addr_i,
    input  logic [NREQ*DW-1:0] wdata_i,
`ifdef ARB_LOCK_EN
    input  logic [NREQ-1:0]    lock_i,
`endif
    output logic [NREQ-1:0]    gnt_o,
    output logic [NREQ-1:0]    rvalid_o,
    output logic [DW-1:0]      rdata_o,
    output logic               ram_en_o,
    output logic               ram_we_o,
    output logic [AW-1:0]      ram_addr_o,
    output logic [DW-1:0]      ram_wdata_o,
    input  logic [DW-1:0]      ram_rdata_i
);

    localparam int PW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > NREQ_MAX) begin : g_nreq_range
        $error("bram_port_arbiter: NREQ must lie in 2..%0d", NREQ_MAX);
    end

    logic [PW-1:0]   ptr;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] pick;
    logic            found;

    logic [PW-1:0]   pick_idx;
    logic            sel_we;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;

    // ------------------------------------------------------------------
    // Eligibility. A requester holding gnt_o this cycle still shows req
    // (it may only drop it now), so it is masked to avoid a second issue.
    // ------------------------------------------------------------------
`ifdef ARB_LOCK_EN
    logic            owner_valid;
    logic [PW-1:0]   owner_idx;
    logic            lock_active;
    logic [NREQ-1:0] owner_mask;

    // Ownership lapses in the very cycle the owner drops lock_i.
    assign lock_active = owner_valid & lock_i[owner_idx];

    always_comb begin
        owner_mask            = '0;
        owner_mask[owner_idx] = 1'b1;
        eligible              = req_i & ~gnt_o;
        if (lock_active) begin
            eligible = eligible & owner_mask;
        end
    end
`else
    assign eligible = req_i & ~gnt_o;
`endif

    rr_pick #(
        .N (NREQ)
    ) u_rr_pick (
        .eligible (eligible),
        .ptr      (ptr),
        .pick     (pick),
        .found    (found)
    );

    // Mux the winning requester's access fields.
    always_comb begin
        pick_idx  = '0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) begin
                pick_idx  = PW'(i);
                sel_we    = we_i[i];
                sel_addr  = addr_i[i*AW +: AW];
                sel_wdata = wdata_i[i*DW +: DW];
            end
        end
    end

    // ------------------------------------------------------------------
    // Grant / RAM port registers. Address and write data hold while idle
    // so the RAM port does not toggle needlessly.
    // ------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_p or negedge rst_top) begin
        if (!rst_top) begin
            gnt_o       <= '0;
            rvalid_o    <= '0;
            ram_en_o    <= 1'b0;
            ram_we_o    <= 1'b0;
            ram_addr_o  <= '0;
            ram_wdata_o <= '0;
            ptr         <= '0;
        end else begin
            gnt_o    <= pick;
            ram_en_o <= found;
            ram_we_o <= found & sel_we;
            if (found) begin
                ram_addr_o  <= sel_addr;
                ram_wdata_o <= sel_wdata;
                ptr         <= PW'(wrap_inc(32'(pick_idx), NREQ));
            end
            // The read issued this cycle lands in the RAM output register
            // at this edge, so its valid appears alongside that data.
            rvalid_o <= gnt_o & {NREQ{ram_en_o & ~ram_we_o}};
        end
    end

    assign rdata_o = ram_rdata_i;

`ifdef ARB_LOCK_EN
    // ptr needs no explicit freeze: only the owner can win while locked,
    // and each owner grant rewrites ptr to owner+1.
    always_ff @(posedge clk_p or negedge rst_top) begin
        if (!rst_top) begin
            owner_valid <= 1'b0;
            owner_idx   <= '0;
        end else if (found && lock_i[pick_idx]) begin
            owner_valid <= 1'b1;
            owner_idx   <= pick_idx;
        end else if (!lock_active) begin
            owner_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bram_port_arbiter
//   Self-checking bench for bram_port_arbiter (NREQ=4). Contains a RAM model
//   with 1-cycle read latency, a transaction-level reference model of the
//   arbitration rules, a per-cycle compare process, directed scenarios with
//   literal expectations, and a randomized traffic phase.
//   Build with ARB_LOCK_EN defined to also exercise the lock feature.
// -----------------------------------------------------------------------------
module tb_bram_port_arbiter;
    import bram_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = RAM_AW;
    localparam int DW = RAM_DW;

    logic            clk_p = 1'b0;
    logic            rst_top;
    logic [N-1:0]    req_i;
    logic [N-1:0]    we_i;
    logic [N*AW-1:0] addr_i;
    logic [N*DW-1:0] wdata_i;
`ifdef ARB_LOCK_EN
    logic [N-1:0]    lock_i;
`endif
    logic [N-1:0]    gnt_o;
    logic [N-1:0]    rvalid_o;
    logic [DW-1:0]   rdata_o;
    logic            ram_en_o;
    logic            ram_we_o;
    logic [AW-1:0]   ram_addr_o;
    logic [DW-1:0]   ram_wdata_o;
    logic [DW-1:0]   ram_rdata_i = '0;

    int n_pass   = 0;
    int n_checks = 0;

    always #5 clk_p = ~clk_p;

    bram_port_arbiter #(.NREQ(N), .AW(AW), .DW(DW)) dut (
        .clk_p       (clk_p),
        .rst_top     (rst_top),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
`ifdef ARB_LOCK_EN
        .lock_i      (lock_i),
`endif
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .ram_en_o    (ram_en_o),
        .ram_we_o    (ram_we_o),
        .ram_addr_o  (ram_addr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata_i)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- RAM port B model (sync read, 1-cycle latency) --------
    logic [DW-1:0] mem [512];
    logic [DW-1:0] ram_rd = '0;

    always @(posedge clk_p) begin
        if (ram_en_o) begin
            if (ram_we_o) mem[ram_addr_o] = ram_wdata_o;
            else          ram_rd = mem[ram_addr_o];
        end
        ram_rdata_i <= ram_rd;
    end

    // ---------------- Reference model -------------------------------------
    // m_gnt: requester holding the grant this cycle (-1 none);
    // m_rv:  requester whose read data is presented this cycle (-1 none).
    logic [DW-1:0] ref_mem [512];
    int            m_gnt   = -1;
    int            m_rv    = -1;
    int            m_ptr   = 0;
    int            m_owner = -1;
    int            m_k;
    int            m_j;
    bit            m_locked;
    bit            m_en    = 1'b0;
    req_bundle_t   m_acc   = '0;
    logic [DW-1:0] m_rdata = '0;

    always @(posedge clk_p or negedge rst_top) begin
        if (!rst_top) begin
            m_gnt = -1; m_rv = -1; m_ptr = 0; m_owner = -1;
            m_en  = 1'b0; m_acc = '0;
        end else begin
            // Retire the access performed during the cycle now ending.
            m_rv = (m_en && !m_acc.we) ? m_gnt : -1;
            if (m_en && !m_acc.we) m_rdata = ref_mem[m_acc.addr];
            if (m_en &&  m_acc.we) ref_mem[m_acc.addr] = m_acc.wdata;

            m_locked = 1'b0;
`ifdef ARB_LOCK_EN
            m_locked = (m_owner >= 0) && (lock_i[m_owner] == 1'b1);
`endif
            m_k = -1;
            for (int off = 0; off < N; off++) begin
                m_j = (m_ptr + off) % N;
                if (m_k < 0 && req_i[m_j] && m_j != m_gnt && (!m_locked || m_j == m_owner))
                    m_k = m_j;
            end
`ifdef ARB_LOCK_EN
            if (m_k >= 0 && lock_i[m_k]) m_owner = m_k;
            else if (!m_locked)          m_owner = -1;
`endif
            m_gnt = m_k;
            if (m_k >= 0) begin
                m_en        = 1'b1;
                m_acc.we    = we_i[m_k];
                m_acc.addr  = addr_i[m_k*AW +: AW];
                m_acc.wdata = wdata_i[m_k*DW +: DW];
                m_ptr       = (m_k + 1) % N;
            end else begin
                m_en     = 1'b0;
                m_acc.we = 1'b0;
            end
        end
    end

    function automatic logic [N-1:0] onehot(input int k);
        logic [N-1:0] v;
        v = '0;
        if (k >= 0) v[k] = 1'b1;
        return v;
    endfunction

    // ---------------- Per-cycle compare -----------------------------------
    always @(negedge clk_p) begin
        check("gnt",       64'(gnt_o),       64'(onehot(m_gnt)));
        check("rvalid",    64'(rvalid_o),    64'(onehot(m_rv)));
        check("ram_en",    64'(ram_en_o),    64'(m_en));
        check("ram_we",    64'(ram_we_o),    64'(m_acc.we));
        check("ram_addr",  64'(ram_addr_o),  64'(m_acc.addr));
        check("ram_wdata", 64'(ram_wdata_o), 64'(m_acc.wdata));
        if (m_rv >= 0) check("rdata", 64'(rdata_o), 64'(m_rdata));
    end

    // ---------------- Stimulus helpers ------------------------------------
    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_i[i]            = 1'b1;
        we_i[i]             = we;
        addr_i[i*AW +: AW]  = a;
        wdata_i[i*DW +: DW] = d;
    endtask

    task automatic pulse_reset();
        @(negedge clk_p); #1 rst_top = 1'b0;
        @(negedge clk_p); #1 rst_top = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int cnt [N];
    int ng;

    initial begin
        req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; rst_top = 1'b1;
`ifdef ARB_LOCK_EN
        lock_i = '0;
`endif
        for (int a = 0; a < 512; a++) begin
            mem[a]     = 32'hA5A5_0000 ^ (a * 32'h0101_0101);
            ref_mem[a] = 32'hA5A5_0000 ^ (a * 32'h0101_0101);
        end
        mem[5]     = 32'hDEAD_BEEF;
        ref_mem[5] = 32'hDEAD_BEEF;

        #1 rst_top = 1'b0;
        repeat (3) @(posedge clk_p);
        #1 rst_top = 1'b1;

        // Idle after reset: every output low.
        repeat (20) begin
            @(negedge clk_p);
            check("idle_outputs", {gnt_o, rvalid_o, ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o}, 64'h0);
        end

        // Single read round trip.
        @(negedge clk_p); set_req(2, 1'b0, 9'h005, 32'h0);
        @(negedge clk_p);
        check("rd_gnt",  64'(gnt_o),      64'h4);
        check("rd_addr", 64'(ram_addr_o), 64'h005);
        req_i[2] = 1'b0;
        @(negedge clk_p);
        check("rd_rvalid", 64'(rvalid_o), 64'h4);
        check("rd_rdata",  64'(rdata_o),  64'hDEAD_BEEF);

        // Write by requester 1, then read back by requester 3.
        @(negedge clk_p); set_req(1, 1'b1, 9'h1A5, 32'h1234_5678);
        @(negedge clk_p);
        check("wr_gnt",   64'(gnt_o),       64'h2);
        check("wr_we",    64'(ram_we_o),    64'h1);
        check("wr_wdata", 64'(ram_wdata_o), 64'h1234_5678);
        req_i[1] = 1'b0;
        set_req(3, 1'b0, 9'h1A5, 32'h0);
        @(negedge clk_p);
        check("wr_no_rvalid", 64'(rvalid_o), 64'h0);
        check("rb_gnt",       64'(gnt_o),    64'h8);
        req_i[3] = 1'b0;
        @(negedge clk_p);
        check("rb_rvalid", 64'(rvalid_o), 64'h8);
        check("rb_rdata",  64'(rdata_o),  64'h1234_5678);

        // Fairness: all four requesting continuously from reset.
        pulse_reset();
        @(negedge clk_p);
        for (int i = 0; i < N; i++) begin
            set_req(i, 1'b0, AW'(i), 32'h0);
            cnt[i] = 0;
        end
        for (int c = 0; c < 16; c++) begin
            @(negedge clk_p);
            check("fair_gnt", 64'(gnt_o), 64'(4'b0001 << (c % 4)));
            for (int i = 0; i < N; i++) if (gnt_o[i]) cnt[i]++;
        end
        req_i = '0;
        for (int i = 0; i < N; i++) check("fair_count", 64'(cnt[i]), 64'd4);
        repeat (2) @(negedge clk_p);

        // Single continuous requester: granted every other cycle.
        @(negedge clk_p); set_req(0, 1'b0, 9'h003, 32'h0);
        ng = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_p);
            check("cont_gnt", 64'(gnt_o), (c % 2 == 0) ? 64'h1 : 64'h0);
            if (gnt_o[0]) ng++;
        end
        req_i = '0;
        check("cont_count", 64'(ng), 64'd5);
        repeat (2) @(negedge clk_p);

        // Reset between read grant and rvalid.
        @(negedge clk_p); set_req(2, 1'b0, 9'h005, 32'h0);
        @(negedge clk_p);
        check("mr_gnt", 64'(gnt_o), 64'h4);
        req_i[2] = 1'b0;
        #1 rst_top = 1'b0;
        #2 rst_top = 1'b1;
        @(negedge clk_p);
        check("mr_rvalid", 64'(rvalid_o), 64'h0);
        for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i), 32'h0);
        @(negedge clk_p);
        check("mr_ptr_zero", 64'(gnt_o), 64'h1);
        req_i = '0;
        repeat (2) @(negedge clk_p);

`ifdef ARB_LOCK_EN
        // Lock: requester 1 takes the bus, 0 and 2 wait.
        @(negedge clk_p); set_req(1, 1'b0, 9'h010, 32'h0); lock_i[1] = 1'b1;
        @(negedge clk_p);
        check("lk_first", 64'(gnt_o), 64'h2);
        set_req(0, 1'b0, 9'h020, 32'h0);
        set_req(2, 1'b0, 9'h030, 32'h0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_p);
            check("lk_gnt", 64'(gnt_o), (c % 2 == 1) ? 64'h2 : 64'h0);
        end
        lock_i[1] = 1'b0;
        req_i[1]  = 1'b0;
        @(negedge clk_p);
        check("lk_release", 64'(gnt_o), 64'h4);
        req_i = '0;
        repeat (2) @(negedge clk_p);
`endif

        // Randomized traffic obeying the requester handshake rules.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk_p);
            for (int i = 0; i < N; i++) begin
                if (m_gnt == i) begin
                    if ($urandom_range(0, 1) == 1)
                        set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom());
                    else
                        req_i[i] = 1'b0;
`ifdef ARB_LOCK_EN
                    lock_i[i] = ($urandom_range(0, 7) == 0);
`endif
                end else if (req_i[i]) begin
                    if ($urandom_range(0, 19) == 0) req_i[i] = 1'b0;
                end else if ($urandom_range(0, 9) < 3) begin
                    set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom());
`ifdef ARB_LOCK_EN
                    lock_i[i] = ($urandom_range(0, 7) == 0);
`endif
                end
            end
        end
        req_i = '0;
`ifdef ARB_LOCK_EN
        lock_i = '0;
`endif
        repeat (4) @(negedge clk_p);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
